// File: rtl/tdc_pulse_sequencer.sv
// START/STOP pulse-pair burst sequencer for TDC characterisation, go/busy/done handshake.
// Optional pairs_sent status counter enabled by defining TDC_SEQ_STATUS_EN.
module tdc_pulse_sequencer #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   delay,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic [BURST_WIDTH-1:0] count,
  output logic                   start_pulse,
  output logic                   stop_pulse,
  output logic                   busy,
  output logic                   done
`ifdef TDC_SEQ_STATUS_EN
  ,
  output logic [BURST_WIDTH-1:0] pairs_sent
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   dm1_q, dm1_d;
  logic [CNT_WIDTH-1:0]   pm1_q, pm1_d;
  logic [CNT_WIDTH-1:0]   d_eff;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic                   start_d, stop_d, busy_d, done_d;
`ifdef TDC_SEQ_STATUS_EN
  logic [BURST_WIDTH-1:0] pairs_d;
`endif

  // Latched as D-1 and P-1 so the counter compares directly; P-1 = max(period-1, D)
  // keeps the clamp inside CNT_WIDTH even when delay is all-ones.
  assign d_eff = (delay == '0) ? CNT_WIDTH'(1) : delay;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dm1_d   = dm1_q;
    pm1_d   = pm1_q;
    rem_d   = rem_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef TDC_SEQ_STATUS_EN
    pairs_d = pairs_sent;
`endif
    case (state_q)
      S_IDLE: begin
        if (go && !abort) begin
          dm1_d = d_eff - CNT_WIDTH'(1);
          pm1_d = (period > d_eff) ? (period - CNT_WIDTH'(1)) : d_eff;
          rem_d = count;
          cnt_d = '0;
`ifdef TDC_SEQ_STATUS_EN
          pairs_d = '0;
`endif
          if (count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RUN;
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (stop_pulse && rem_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == dm1_q) begin
            stop_d = 1'b1;
            rem_d  = rem_q - BURST_WIDTH'(1);
`ifdef TDC_SEQ_STATUS_EN
            pairs_d = pairs_sent + BURST_WIDTH'(1);
`endif
          end else if (cnt_q == pm1_q && rem_q != '0) begin
            start_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dm1_q       <= '0;
      pm1_q       <= '0;
      rem_q       <= '0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef TDC_SEQ_STATUS_EN
      pairs_sent  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm1_q       <= dm1_d;
      pm1_q       <= pm1_d;
      rem_q       <= rem_d;
      start_pulse <= start_d;
      stop_pulse  <= stop_d;
      busy        <= busy_d;
      done        <= done_d;
`ifdef TDC_SEQ_STATUS_EN
      pairs_sent  <= pairs_d;
`endif
    end
  end

endmodule

// File: tb/tb_tdc_pulse_sequencer.sv
// Self-checking bench for tdc_pulse_sequencer: table of bursts with a per-cycle scoreboard
// built from the closed-form pulse schedule, plus hand-written reset and idle-abort sequences.
module tb_tdc_pulse_sequencer;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] delay = '0;
  logic [CW-1:0] period = '0;
  logic [BW-1:0] count = '0;
  logic          start_pulse, stop_pulse, busy, done;
`ifdef TDC_SEQ_STATUS_EN
  logic [BW-1:0] pairs_sent;
`endif

  tdc_pulse_sequencer #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .abort      (abort),
    .delay      (delay),
    .period     (period),
    .count      (count),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse),
    .busy       (busy),
    .done       (done)
`ifdef TDC_SEQ_STATUS_EN
    ,
    .pairs_sent (pairs_sent)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    int period;
    int count;
    int abort_at;    // cycle in which abort is held high, 0 = none
    int repulse_at;  // cycle in which go is re-pulsed with new inputs, 0 = none
    int exp_done;    // cycle done is expected, 0 = never
    int exp_pairs;   // STOP pulses expected in the burst
  } vec_t;

  typedef struct packed {
    logic s;
    logic p;
    logic b;
    logic d;
  } out_t;

  out_t sbq[$];
  vec_t tbl[7];
  int   checks = 0;
  int   failures = 0;

  function automatic out_t model(vec_t v, int j);
    int d, p, last;
    out_t o;
    o = '0;
    d = (v.delay == 0) ? 1 : v.delay;
    p = (v.period > d) ? v.period : d + 1;
    last = (v.count == 0) ? 0 : (v.count - 1) * p + d + 1;
    if (v.count == 0) begin
      o.d = (j == 1);
    end else begin
      o.s = ((j - 1) % p == 0) && ((j - 1) / p < v.count);
      o.p = (j - 1 >= d) && ((j - 1 - d) % p == 0) && ((j - 1 - d) / p < v.count);
      o.b = (j >= 1) && (j <= last);
      o.d = (j == last + 1);
    end
    if (v.abort_at != 0 && v.abort_at <= last && j > v.abort_at) o = '0;
    return o;
  endfunction

  function automatic int burst_len(vec_t v);
    int d, p;
    d = (v.delay == 0) ? 1 : v.delay;
    p = (v.period > d) ? v.period : d + 1;
    return (v.count == 0) ? 4 : (v.count - 1) * p + d + 5;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int   n, first_done;
    out_t got, exp;
    n = burst_len(v);
    first_done = 0;
    @(negedge clk);
    delay  = CW'(v.delay);
    period = CW'(v.period);
    count  = BW'(v.count);
    go     = 1'b1;
    for (int j = 1; j <= n; j++) sbq.push_back(model(v, j));
    @(posedge clk);
    #1 go = 1'b0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      go    = 1'b0;
      abort = 1'b0;
      got = '{s: start_pulse, p: stop_pulse, b: busy, d: done};
      exp = sbq.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL vec%0d cycle=%0d got start/stop/busy/done=%b%b%b%b expected=%b%b%b%b",
                 idx, j, got.s, got.p, got.b, got.d, exp.s, exp.p, exp.b, exp.d);
      end
      if (done === 1'b1 && first_done == 0) first_done = j;
      if (j == v.abort_at) abort = 1'b1;
      if (j == v.repulse_at) begin
        go     = 1'b1;
        delay  = CW'(1);
        period = CW'(3);
        count  = BW'(9);
      end
    end
    go    = 1'b0;
    abort = 1'b0;
    checks++;
    if (first_done != v.exp_done) begin
      failures++;
      $display("FAIL vec%0d done_cycle got=%0d expected=%0d", idx, first_done, v.exp_done);
    end
`ifdef TDC_SEQ_STATUS_EN
    checks++;
    if (int'(pairs_sent) != v.exp_pairs) begin
      failures++;
      $display("FAIL vec%0d pairs_sent got=%0d expected=%0d", idx, pairs_sent, v.exp_pairs);
    end
`endif
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({start_pulse, stop_pulse, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL %s got start/stop/busy/done=%b%b%b%b expected=0000",
               name, start_pulse, stop_pulse, busy, done);
    end
  endtask

  initial begin
    tbl[0] = '{3, 10, 4, 0, 0, 35, 4};
    tbl[1] = '{0, 0, 2, 0, 0, 5, 2};
    tbl[2] = '{7, 3, 0, 0, 0, 1, 0};
    tbl[3] = '{5, 20, 3, 15, 0, 0, 1};
    tbl[4] = '{3, 10, 4, 0, 5, 35, 4};
    tbl[5] = '{4, 4, 3, 0, 0, 16, 3};
    tbl[6] = '{1, 2, 1, 0, 0, 3, 1};

    #12;
    check_quiet("reset_state");
`ifdef TDC_SEQ_STATUS_EN
    checks++;
    if (pairs_sent !== '0) begin
      failures++;
      $display("FAIL reset_pairs got=%0d expected=0", pairs_sent);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, tbl[i]);
      repeat (2) @(negedge clk);
    end

    // abort while idle must not disturb anything
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("idle_abort");
    end
    abort = 1'b0;

    // reset in cycle 12 of a burst: outputs drop at once, then a clean restart
    @(negedge clk);
    delay  = CW'(3);
    period = CW'(10);
    count  = BW'(4);
    go     = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_busy got=%b expected=1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    @(negedge clk);
    check_quiet("held_reset");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("post_reset_idle");
    end
    run_vec(7, tbl[0]);
    run_vec(8, tbl[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
